// File: rtl/div_pkg.sv
// div_pkg: shared types and default widths for the div unit.
// Holds the FSM state encoding and a counter-width helper.
package div_pkg;

    localparam int A_W = 16;
    localparam int B_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring division step.
// Shifts in a dividend bit, trial-subtracts the divisor, restores on borrow.
module div_step #(
    parameter int B_W = 8
) (
    input  logic [B_W:0]   rem,
    input  logic           din,
    input  logic [B_W-1:0] b,
    output logic [B_W:0]   rem_nx,
    output logic           qbit
);

    logic [B_W+1:0] sh;
    logic [B_W:0]   diff;

    // trial subtract; keep difference only when it does not go negative
    always_comb begin
        sh     = {rem, din};
        qbit   = (sh >= {2'b00, b});
        diff   = sh[B_W:0] - {1'b0, b};
        rem_nx = qbit ? diff : sh[B_W:0];
    end

endmodule

// File: rtl/div.sv
// div: sequential unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN adds dz_o and a zero-divisor fast path.
module div #(
    parameter int A_W = div_pkg::A_W,
    parameter int B_W = div_pkg::B_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [A_W-1:0] a_bi,
    input  logic [B_W-1:0] b_bi,
    input  logic           start_i,
    output logic           busy_o,
    output logic [A_W-1:0] q_bo,
    output logic [B_W-1:0] r_bo
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic           dz_o
`endif
);

    import div_pkg::*;

    localparam int CW = cnt_w(A_W);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [A_W-1:0] aq;
    logic [B_W-1:0] bq;
    logic [B_W:0]   rem;
    logic [B_W:0]   rem_nx;
    logic           qbit;
    logic [A_W-1:0] q_r;
    logic [B_W-1:0] r_r;
    logic           bz;
    logic           load;
    logic           step;
    logic           done;
    logic           zero;

`ifdef DIV_ZERO_DETECT_EN
    assign bz = (b_bi == '0);
`else
    assign bz = 1'b0;
`endif

    div_step #(
        .B_W(B_W)
    ) u_step (
        .rem   (rem),
        .din   (aq[A_W-1]),
        .b     (bq),
        .rem_nx(rem_nx),
        .qbit  (qbit)
    );

    // next-state and datapath control
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        done     = 1'b0;
        zero     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    if (bz) begin
                        zero = 1'b1;
                    end else begin
                        load     = 1'b1;
                        state_nx = WORK;
                    end
                end
            end
            WORK: begin
                step = 1'b1;
                if (cnt == '0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // operand latch, shift/subtract iteration and result capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
            aq  <= '0;
            bq  <= '0;
            rem <= '0;
            q_r <= '0;
            r_r <= '0;
        end else begin
            if (load) begin
                aq  <= a_bi;
                bq  <= b_bi;
                rem <= '0;
                cnt <= CW'(A_W - 1);
            end
            if (step) begin
                aq  <= {aq[A_W-2:0], qbit};
                rem <= rem_nx;
                cnt <= cnt - CW'(1);
            end
            if (done) begin
                q_r <= {aq[A_W-2:0], qbit};
                r_r <= rem_nx[B_W-1:0];
            end
            if (zero) begin
                q_r <= '1;
                r_r <= '0;
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    // sticky zero-divisor flag, cleared by the next real start
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)    dz_o <= 1'b0;
        else if (zero) dz_o <= 1'b1;
        else if (load) dz_o <= 1'b0;
    end
`endif

    assign busy_o = (state == WORK);
    assign q_bo   = q_r;
    assign r_bo   = r_r;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The module SHALL have parameter A_W, default 16, meaning dividend and quotient width.
REQ-002 The module SHALL have parameter B_W, default 8, meaning divisor and remainder width.
REQ-003 The module SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port a_bi, input, A_W, the unsigned dividend.
REQ-006 The module SHALL have port b_bi, input, B_W, the unsigned divisor.
REQ-007 The module SHALL have port start_i, input, 1, the operation request, sampled only while idle.
REQ-008 The module SHALL have port busy_o, output, 1, high while an operation is in progress.
REQ-009 The module SHALL have port q_bo, output, A_W, the quotient.
REQ-010 The module SHALL have port r_bo, output, B_W, the remainder.
REQ-011 The module SHALL have port dz_o, output, 1, divide-by-zero flag, present only with DIV_ZERO_DETECT_EN (REQ-027).

Function
REQ-012 The module SHALL implement FSM states IDLE and WORK.
REQ-013 In IDLE with start_i=1 at edge k, the module SHALL latch a_bi and b_bi, clear the partial remainder, load the bit counter with A_W-1, and enter WORK; busy_o SHALL be 1 after edge k.
REQ-014 In WORK, each edge SHALL perform one restoring step: shift the remainder left, shifting in the next dividend MSB; subtract the divisor; set the quotient bit to 1 and keep the difference if it is non-negative, else set the bit to 0 and restore.
REQ-015 The partial remainder register SHALL be B_W+1 bits wide, so no step overflows.
REQ-016 After A_W WORK cycles (edge k+A_W), the FSM SHALL return to IDLE, busy_o SHALL be 0, and q_bo and r_bo SHALL hold the final results.
REQ-017 Latency SHALL be exactly A_W cycles from the start edge to busy_o falling (16 at defaults).
REQ-018 q_bo and r_bo SHALL remain stable in IDLE until the next accepted start.
REQ-019 start_i SHALL be ignored while busy_o=1; a_bi and b_bi SHALL NOT affect a running operation.
REQ-020 start_i held high SHALL begin a new operation on the first edge in IDLE, so back-to-back operations have one idle cycle between them.
REQ-021 Results SHALL satisfy a = q*b + r with r < b for every b != 0.

Reset
REQ-022 When rst_i=0, the module SHALL immediately, without a clock, force the FSM to IDLE, busy_o to 0, q_bo to 0, r_bo to 0, the counter to 0, and dz_o (if present) to 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no result retained.
REQ-024 After rst_i is released, the first rising edge with start_i=1 SHALL start a new operation normally.

Configuration
REQ-025 The module SHALL provide the macro DIV_ZERO_DETECT_EN.
REQ-026 With DIV_ZERO_DETECT_EN defined, a start with b_bi=0 SHALL cause the next edge to set q_bo to all ones, r_bo to 0 and dz_o to 1, with busy_o staying 0 and no WORK cycles.
REQ-027 With DIV_ZERO_DETECT_EN defined, dz_o SHALL clear on the next accepted start that has a nonzero divisor.
REQ-028 Without DIV_ZERO_DETECT_EN, port dz_o SHALL be absent, and b_bi=0 SHALL run the normal A_W-cycle algorithm with q_bo all ones and r_bo unspecified.

Structure
REQ-029 Package div_pkg SHALL hold the FSM state typedef (IDLE, WORK) and the default width constants A_W and B_W.
REQ-030 A combinational sub-module div_step SHALL perform one shift/subtract/restore step, instantiated once.

Verification
REQ-031 The bench SHALL check: a=0xFFFF, b=0x06, start for one cycle -> busy_o high for 16 cycles, then q=0x2AAA, r=0x03.
REQ-032 The bench SHALL check: a=0x05FA, b=0xFF -> q=0x0006, r=0x00 (inverse of 0xFF*0x06).
REQ-033 The bench SHALL check: a=0x0007, b=0x09 -> q=0x0000, r=0x07; and a=0x0064, b=0x01 -> q=0x0064, r=0x00.
REQ-034 The bench SHALL check: start with a=0x1234, b=0x10, then a second start at cycle 5 with a=0xFFFF, b=0x01 -> second start ignored, q=0x0123, r=0x04.
REQ-035 The bench SHALL check: rst_i=0 at cycle 8 of an operation -> busy_o, q_bo and r_bo are 0 immediately, before the next edge.
REQ-036 The bench SHALL check, with DIV_ZERO_DETECT_EN: a=0x0055, b=0x00 -> one cycle later dz_o=1, q=0xFFFF, r=0x00, busy_o never high.
